// File: rtl/d0_scheduler.sv
// d0_scheduler: d0 request arbiter with power-on/flush line-invalidation sweep
// Ports:
//   clk_i, rst_i                          clock, async active-high reset
//   flush_i                               restart the invalidation sweep
//   stall_i                               d0 cannot accept a request this cycle
//   d1/l2c/upd/lsq_valid_i                pending requests per source
//   d1/l2c/upd/lsq_ready_o                grant to the winning source
//   winner_o                              source scheduled this cycle
//   rst_idx_o                             set index invalidated when winner_o==RstBlock
//   rst_done_o                            sweep complete, cache usable
package d0_scheduler_pkg;
  typedef enum logic [2:0] {
    None     = 3'd0,
    LSQ      = 3'd1,
    UpdateL2 = 3'd2,
    L2Cache  = 3'd3,
    D1       = 3'd4,
    RstBlock = 3'd5
  } d0_winner_e;
endpackage

module d0_scheduler
  import d0_scheduler_pkg::*;
#(
  parameter int IDX_LEN      = 6,
  parameter int LSQ_MAX_WAIT = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               d1_valid_i,
  input  logic               l2c_valid_i,
  input  logic               upd_valid_i,
  input  logic               lsq_valid_i,
  output logic               d1_ready_o,
  output logic               l2c_ready_o,
  output logic               upd_ready_o,
  output logic               lsq_ready_o,
  output d0_winner_e         winner_o,
  output logic [IDX_LEN-1:0] rst_idx_o,
  output logic               rst_done_o
);
  localparam int WW = $clog2(LSQ_MAX_WAIT + 1);
  typedef enum logic {S_SWEEP, S_RUN} state_e;
  state_e             state, state_nxt;
  logic [IDX_LEN-1:0] idx, idx_nxt;
  logic [WW-1:0]      wait_q, wait_nxt;
  d0_winner_e         win;
  logic               run, prom;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= S_SWEEP;
      idx    <= '0;
      wait_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      wait_q <= wait_nxt;
    end
  // rst_i gates the winner combinationally so no handshake completes in the reset cycle
  always_comb begin
    run  = state == S_RUN;
    prom = wait_q == WW'(LSQ_MAX_WAIT);
    win  = (rst_i || stall_i)       ? None     :
           !run                     ? RstBlock :
           d1_valid_i               ? D1       :
           l2c_valid_i              ? L2Cache  :
           (prom && lsq_valid_i)    ? LSQ      :
           upd_valid_i              ? UpdateL2 :
           lsq_valid_i              ? LSQ      : None;
    state_nxt = flush_i ? S_SWEEP :
                (!run && !stall_i && &idx) ? S_RUN : state;
    idx_nxt   = (flush_i || run) ? '0 : stall_i ? idx : idx + 1'b1;
    wait_nxt  = (!lsq_valid_i || win == LSQ) ? '0 :
                (run && !stall_i && !prom) ? wait_q + 1'b1 : wait_q;
  end
  assign d1_ready_o  = win == D1;
  assign l2c_ready_o = win == L2Cache;
  assign upd_ready_o = win == UpdateL2;
  assign lsq_ready_o = win == LSQ;
  assign winner_o    = win;
  assign rst_idx_o   = idx;
  assign rst_done_o  = run;
endmodule

// File: tb/tb_d0_scheduler.sv
// tb_d0_scheduler: scoreboard bench for d0_scheduler sweep, priority and LSQ ageing
module tb_d0_scheduler;
  import d0_scheduler_pkg::*;
  logic clk = 0, rst = 1, flush = 0, stall = 0;
  logic [3:0] v = 4'h0;
  d0_winner_e winner;
  logic [5:0] idx;
  logic d1r, l2r, upr, lqr, done;
  string phase = "reset";
  int n_chk = 0, n_pass = 0;
  typedef struct {
    int w;
    int rdy;
    int idx;
    int done;
  } exp_t;
  exp_t sb[$];

  d0_scheduler dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .d1_valid_i(v[3]), .l2c_valid_i(v[2]), .upd_valid_i(v[1]), .lsq_valid_i(v[0]),
    .d1_ready_o(d1r), .l2c_ready_o(l2r), .upd_ready_o(upr), .lsq_ready_o(lqr),
    .winner_o(winner), .rst_idx_o(idx), .rst_done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
  endtask

  // v = {d1, l2c, upd, lsq}; rdy uses the same bit order
  task automatic step(input logic r, input logic f, input logic s, input logic [3:0] vv,
                      input d0_winner_e w, input logic [3:0] rdy, input int i, input logic dn);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush = f; stall = s; v = vv;
    sb.push_back('{int'(w), int'(rdy), i, int'(dn)});
    @(negedge clk);
    e = sb.pop_front();
    check("winner", int'(winner), e.w);
    check("ready", int'({d1r, l2r, upr, lqr}), e.rdy);
    check("idx", int'(idx), e.idx);
    check("done", int'(done), e.done);
  endtask

  task automatic sweep(input int from, input int to);
    for (int i = from; i <= to; i++) step(0, 0, 0, 4'hF, RstBlock, 4'h0, i, 0);
  endtask

  task automatic rep(input int n, input logic s, input logic [3:0] vv,
                     input d0_winner_e w, input logic [3:0] rdy);
    for (int k = 0; k < n; k++) step(0, 0, s, vv, w, rdy, 0, 1);
  endtask

  initial begin
    step(1, 0, 0, 4'hF, None, 4'h0, 0, 0);
    step(1, 0, 0, 4'hF, None, 4'h0, 0, 0);
    phase = "sweep1";
    sweep(0, 63);
    phase = "prio";
    rep(1, 0, 4'b1111, D1, 4'b1000);
    rep(1, 0, 4'b0111, L2Cache, 4'b0100);
    rep(1, 0, 4'b0000, None, 4'b0000);
    rep(1, 1, 4'b1111, None, 4'b0000);
    phase = "lsq_age";
    rep(8, 0, 4'b0011, UpdateL2, 4'b0010);
    rep(1, 0, 4'b0011, LSQ, 4'b0001);
    rep(1, 0, 4'b0011, UpdateL2, 4'b0010);
    phase = "lsq_prom";
    rep(1, 0, 4'b0000, None, 4'b0000);
    rep(8, 0, 4'b0011, UpdateL2, 4'b0010);
    rep(1, 0, 4'b1011, D1, 4'b1000);
    rep(1, 0, 4'b0111, L2Cache, 4'b0100);
    rep(1, 0, 4'b0011, LSQ, 4'b0001);
    phase = "stall_hold";
    rep(5, 0, 4'b0011, UpdateL2, 4'b0010);
    rep(3, 1, 4'b0011, None, 4'b0000);
    rep(3, 0, 4'b0011, UpdateL2, 4'b0010);
    rep(1, 0, 4'b0011, LSQ, 4'b0001);
    phase = "flush_run";
    step(0, 1, 0, 4'b0001, LSQ, 4'b0001, 0, 1);
    phase = "sweep_stall";
    sweep(0, 9);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 4'hF, None, 4'h0, 10, 0);
    sweep(10, 63);
    step(0, 0, 0, 4'h0, None, 4'h0, 0, 1);
    phase = "flush_sweep";
    step(0, 1, 0, 4'h0, None, 4'h0, 0, 1);
    sweep(0, 2);
    step(0, 1, 0, 4'hF, RstBlock, 4'h0, 3, 0);
    sweep(0, 30);
    phase = "mid_rst";
    step(1, 0, 0, 4'hF, None, 4'h0, 0, 0);
    phase = "post_rst";
    sweep(0, 63);
    step(0, 0, 0, 4'hF, D1, 4'b1000, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
